jtag_master: RTL



---
 rtl/jtag_pkg.sv | 16 +
 rtl/jtag_tck_div.sv | 37 +++
 rtl/jtag_master.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/jtag_pkg.sv
// Shared types and helpers for the JTAG master.
package jtag_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    RSP  = 2'd3
  } jtag_state_e;

  // Width needed to hold a bit count in the range 0..max_bits.
  function automatic int jtag_len_w(input int max_bits);
    return $clog2(max_bits + 1);
  endfunction

endpackage

// File: rtl/jtag_tck_div.sv
// TCK half-period timer: start loads CLK_DIV-1, expire flags the last clk of the half-period.
module jtag_tck_div #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic start_i,
  output logic expire_o
);

  localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] RELOAD = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Reload on start, otherwise count down and park at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (start_i) begin
      cnt_d = RELOAD;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = (cnt_q == '0);

endmodule

// File: rtl/jtag_master.sv
// Host-side JTAG shifter: drives TCK/TMS/TDI for one command and returns captured TDO.
module jtag_master
  import jtag_pkg::*;
#(
  parameter int unsigned CLK_DIV  = 2,
  parameter int unsigned MAX_BITS = 32,
  parameter int unsigned LEN_W    = jtag_len_w(MAX_BITS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [MAX_BITS-1:0] cmd_tms,
  input  logic [MAX_BITS-1:0] cmd_tdi,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [MAX_BITS-1:0] rsp_data,
  output logic                busy,
  output logic                tck,
  output logic                tms,
  output logic                tdi,
  input  logic                tdo
);

  jtag_state_e state_q, state_d;

  logic [LEN_W-1:0]    len_q;
  logic [LEN_W-1:0]    idx_q;
  logic [MAX_BITS-1:0] tms_sr_q;
  logic [MAX_BITS-1:0] tdi_sr_q;
  logic [MAX_BITS-1:0] rsp_data_q, cap_d;
  logic                tck_q, tms_q, tdi_q;

  logic             accept;
  logic             div_start, div_expire;
  logic             last_bit;
  logic [LEN_W-1:0] len_in;

  assign accept   = cmd_valid & cmd_ready;
  assign len_in   = (cmd_len > LEN_W'(MAX_BITS)) ? LEN_W'(MAX_BITS) : cmd_len;
  assign last_bit = ((idx_q + LEN_W'(1)) == len_q);

  jtag_tck_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (div_start),
    .expire_o (div_expire)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (accept) state_d = (len_in == '0) ? RSP : LOW;
      LOW:  if (div_expire) state_d = HIGH;
      HIGH: if (div_expire) state_d = last_bit ? RSP : LOW;
      RSP:  if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs; the divider restarts on every entry into a TCK half-period.
  always_comb begin
    cmd_ready = (state_q == IDLE) & ~rst;
    rsp_valid = (state_q == RSP);
    busy      = (state_q != IDLE);
    div_start = (state_d != state_q) && ((state_d == LOW) || (state_d == HIGH));
  end

  // Capture: TDO lands in the bit slot selected by the current index.
  always_comb begin
    cap_d = rsp_data_q;
    for (int unsigned i = 0; i < MAX_BITS; i++) begin
      if (idx_q == LEN_W'(i)) cap_d[i] = tdo;
    end
  end

  // Datapath: command latches, pin drivers and response register.
  // TMS/TDI come from right-shifting copies of the command so bit idx is always at [0].
  always_ff @(posedge clk) begin
    if (rst) begin
      tck_q      <= 1'b0;
      tms_q      <= 1'b1;
      tdi_q      <= 1'b0;
      rsp_data_q <= '0;
      len_q      <= '0;
      idx_q      <= '0;
      tms_sr_q   <= '0;
      tdi_sr_q   <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            len_q      <= len_in;
            idx_q      <= '0;
            rsp_data_q <= '0;
            if (len_in != '0) begin
              tms_q    <= cmd_tms[0];
              tdi_q    <= cmd_tdi[0];
              tms_sr_q <= cmd_tms >> 1;
              tdi_sr_q <= cmd_tdi >> 1;
            end
          end
        end
        LOW: begin
          if (div_expire) begin
            tck_q      <= 1'b1;
            rsp_data_q <= cap_d;
          end
        end
        HIGH: begin
          if (div_expire) begin
            tck_q <= 1'b0;
            if (!last_bit) begin
              idx_q    <= idx_q + LEN_W'(1);
              tms_q    <= tms_sr_q[0];
              tdi_q    <= tdi_sr_q[0];
              tms_sr_q <= tms_sr_q >> 1;
              tdi_sr_q <= tdi_sr_q >> 1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign tck      = tck_q;
  assign tms      = tms_q;
  assign tdi      = tdi_q;
  assign rsp_data = rsp_data_q;

endmodule
